// File: rtl/cache_controller.sv
// Sequencing FSM for one cache level: hit handling, victim writeback, line fill
// and install against a request/response memory port, plus saturating counters.
module cache_controller #(
  parameter bit READ_ONLY = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_write,
  output logic                 cpu_req_ready,
  output logic                 cpu_resp_valid,
  input  logic                 valid_block_match,
  input  logic                 valid_dirty_bit,
  output logic                 miss_recovery_mode,
  output logic                 process_lru_counters,
  output logic                 clear_selected_valid_bit,
  output logic                 finish_new_line_install,
  output logic                 clear_selected_dirty_bit,
  output logic                 set_selected_dirty_bit,
  output logic                 mem_req_valid,
  output logic                 mem_req_write,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  output logic                 data_write_en,
  output logic                 data_fill_en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOOKUP    = 4'd1,
    S_VICTIM    = 4'd2,
    S_WB_REQ    = 4'd3,
    S_WB_WAIT   = 4'd4,
    S_FILL_REQ  = 4'd5,
    S_FILL_WAIT = 4'd6,
    S_INSTALL   = 4'd7,
    S_RESPOND   = 4'd8
  } state_e;

  state_e               state_q, state_d;
  logic                 wr_q, wr_d;
  logic [CNT_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d, wb_q, wb_d;
  logic                 victim_dirty;

  // Handshakes: a CPU request transfers when cpu_req_valid is seen while ready
  // (IDLE); a memory request transfers on mem_req_valid && mem_req_ready and
  // holds valid/write stable until then; mem_resp_valid counts only in *_WAIT.
  assign victim_dirty = valid_dirty_bit && !READ_ONLY;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    wb_d    = wb_q;
    case (state_q)
      S_IDLE: if (cpu_req_valid) begin
        wr_d    = cpu_req_write && !READ_ONLY;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (valid_block_match) begin
          if (hit_q != '1) hit_d = hit_q + CNT_WIDTH'(1);
          state_d = S_RESPOND;
        end else begin
          if (miss_q != '1) miss_d = miss_q + CNT_WIDTH'(1);
          state_d = S_VICTIM;
        end
      end
      S_VICTIM:  state_d = victim_dirty ? S_WB_REQ : S_FILL_REQ;
      S_WB_REQ:  if (mem_req_ready) state_d = S_WB_WAIT;
      S_WB_WAIT: if (mem_resp_valid) begin
        if (wb_q != '1) wb_d = wb_q + CNT_WIDTH'(1);
        state_d = S_FILL_REQ;
      end
      S_FILL_REQ:  if (mem_req_ready) state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_resp_valid) state_d = S_INSTALL;
      S_INSTALL:   state_d = S_RESPOND;
      S_RESPOND:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    cpu_req_ready            = 1'b0;
    cpu_resp_valid           = 1'b0;
    miss_recovery_mode       = 1'b0;
    process_lru_counters     = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    set_selected_dirty_bit   = 1'b0;
    mem_req_valid            = 1'b0;
    mem_req_write            = 1'b0;
    data_write_en            = 1'b0;
    data_fill_en             = 1'b0;
    case (state_q)
      S_IDLE: cpu_req_ready = reset_n;
      S_LOOKUP: begin
        process_lru_counters   = valid_block_match;
        set_selected_dirty_bit = valid_block_match && wr_q;
        data_write_en          = valid_block_match && wr_q;
      end
      S_VICTIM: begin
        miss_recovery_mode       = 1'b1;
        clear_selected_valid_bit = !victim_dirty;
      end
      S_WB_REQ: begin
        miss_recovery_mode = 1'b1;
        mem_req_valid      = 1'b1;
        mem_req_write      = !READ_ONLY;
      end
      S_WB_WAIT: begin
        miss_recovery_mode       = 1'b1;
        clear_selected_valid_bit = mem_resp_valid;
        clear_selected_dirty_bit = mem_resp_valid && !READ_ONLY;
      end
      S_FILL_REQ: begin
        miss_recovery_mode = 1'b1;
        mem_req_valid      = 1'b1;
      end
      S_FILL_WAIT: begin
        miss_recovery_mode = 1'b1;
        data_fill_en       = mem_resp_valid;
      end
      // A freshly filled line is clean unless this request stores into it.
      S_INSTALL: begin
        miss_recovery_mode       = 1'b1;
        finish_new_line_install  = 1'b1;
        process_lru_counters     = 1'b1;
        set_selected_dirty_bit   = wr_q;
        data_write_en            = wr_q;
        clear_selected_dirty_bit = !wr_q && !READ_ONLY;
      end
      S_RESPOND: cpu_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: a read/write instance and a READ_ONLY instance,
// both with 2-bit counters, driven from per-cycle {inputs, expected outputs} tables.
module tb_cache_controller;

  localparam logic [12:0] RDY  = 13'h1000, RSP = 13'h0800, MRM = 13'h0400;
  localparam logic [12:0] LRU  = 13'h0200, CLV = 13'h0100, FIN = 13'h0080;
  localparam logic [12:0] CLD  = 13'h0040, SETD = 13'h0020, MRV = 13'h0010;
  localparam logic [12:0] MRW  = 13'h0008, DWE = 13'h0004, DFE = 13'h0002;
  localparam logic [12:0] BSY  = 13'h0001;
  localparam logic [5:0]  I_V  = 6'h20, I_W = 6'h10, I_M = 6'h08;
  localparam logic [5:0]  I_D  = 6'h04, I_R = 6'h02, I_P = 6'h01;

  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [18:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n;
  logic       cpu_req_valid, cpu_req_write, valid_block_match, valid_dirty_bit;
  logic       mem_req_ready, mem_resp_valid;
  logic [1:0] cpu_req_ready, cpu_resp_valid, mrm, lru, clrv, fin, clrd, setd;
  logic [1:0] mreqv, mreqw, dwe, dfe, busy;
  logic [1:0] hit_c [2];
  logic [1:0] miss_c [2];
  logic [1:0] wb_c [2];
  logic [3:0] st_dbg [2];

  vec_t        tbl[$];
  logic [18:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_controller #(.READ_ONLY(g == 1), .CNT_WIDTH(2)) u_dut (
      .clk(clk), .reset_n(rst_n[g]),
      .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
      .cpu_req_ready(cpu_req_ready[g]), .cpu_resp_valid(cpu_resp_valid[g]),
      .valid_block_match(valid_block_match), .valid_dirty_bit(valid_dirty_bit),
      .miss_recovery_mode(mrm[g]), .process_lru_counters(lru[g]),
      .clear_selected_valid_bit(clrv[g]), .finish_new_line_install(fin[g]),
      .clear_selected_dirty_bit(clrd[g]), .set_selected_dirty_bit(setd[g]),
      .mem_req_valid(mreqv[g]), .mem_req_write(mreqw[g]),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .data_write_en(dwe[g]), .data_fill_en(dfe[g]), .busy(busy[g]),
      .hit_count(hit_c[g]), .miss_count(miss_c[g]), .wb_count(wb_c[g]),
      .state_dbg(st_dbg[g])
    );
  end

  function automatic logic [18:0] actual(input int g);
    return {cpu_req_ready[g], cpu_resp_valid[g], mrm[g], lru[g], clrv[g], fin[g],
            clrd[g], setd[g], mreqv[g], mreqw[g], dwe[g], dfe[g], busy[g],
            hit_c[g], miss_c[g], wb_c[g]};
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic check(input string nm, input logic [18:0] got, input logic [18:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b want %b (outs|hit|miss|wb)", nm, got, want);
    end
  endtask

  task automatic add(input string nm, input logic [5:0] in, input logic [12:0] o,
                     input int h, input int m, input int w);
    vec_t r;
    r.name = nm;
    r.in   = in;
    r.exp  = {o, 2'(h), 2'(m), 2'(w)};
    tbl.push_back(r);
  endtask

  task automatic set_inputs(input logic [5:0] in);
    {cpu_req_valid, cpu_req_write, valid_block_match, valid_dirty_bit,
     mem_req_ready, mem_resp_valid} = in;
  endtask

  // Entered and left just after a rising edge; compares on the falling edge.
  task automatic run_table(input int g);
    for (int i = 0; i < tbl.size(); i++) begin
      set_inputs(tbl[i].in);
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
      check($sformatf("%s[%0d]", tbl[i].name, i), actual(g), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 2'b00;
    set_inputs(I_V | I_W | I_M | I_D | I_R | I_P);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rw", actual(0), 19'd0);
    check("reset_ro", actual(1), 19'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;

    add("rd_hit", I_V, RDY, 0, 0, 0);
    add("rd_hit", I_V | I_M, LRU | BSY, 0, 0, 0);
    add("rd_hit", I_V, RSP | BSY, 1, 0, 0);
    add("wr_hit", I_V | I_W, RDY, 1, 0, 0);
    add("wr_hit", I_M, LRU | SETD | DWE | BSY, 1, 0, 0);
    add("wr_hit", 6'h0, RSP | BSY, 2, 0, 0);
    add("wr_miss", I_V | I_W, RDY, 2, 0, 0);
    add("wr_miss", 6'h0, BSY, 2, 0, 0);
    add("wr_miss", 6'h0, MRM | CLV | BSY, 2, 1, 0);
    add("wr_miss", I_R, MRM | MRV | BSY, 2, 1, 0);
    add("wr_miss", I_P, MRM | DFE | BSY, 2, 1, 0);
    add("wr_miss", 6'h0, MRM | LRU | FIN | SETD | DWE | BSY, 2, 1, 0);
    add("wr_miss", 6'h0, RSP | BSY, 2, 1, 0);
    add("dirty", I_V, RDY, 2, 1, 0);
    add("dirty", I_D, BSY, 2, 1, 0);
    add("dirty", I_D, MRM | BSY, 2, 2, 0);
    add("dirty", I_R, MRM | MRV | MRW | BSY, 2, 2, 0);
    add("dirty", I_P, MRM | CLV | CLD | BSY, 2, 2, 0);
    add("dirty", I_R, MRM | MRV | BSY, 2, 2, 1);
    add("dirty", I_P, MRM | DFE | BSY, 2, 2, 1);
    add("dirty", 6'h0, MRM | LRU | FIN | CLD | BSY, 2, 2, 1);
    add("dirty", 6'h0, RSP | BSY, 2, 2, 1);
    add("bp", I_V, RDY, 2, 2, 1);
    add("bp", 6'h0, BSY, 2, 2, 1);
    add("bp", 6'h0, MRM | CLV | BSY, 2, 3, 1);
    for (int k = 0; k < 5; k++) add("bp", (k == 1) ? I_P : 6'h0, MRM | MRV | BSY, 2, 3, 1);
    add("bp", I_R, MRM | MRV | BSY, 2, 3, 1);
    add("bp", 6'h0, MRM | BSY, 2, 3, 1);
    add("bp", I_P, MRM | DFE | BSY, 2, 3, 1);
    add("bp", 6'h0, MRM | LRU | FIN | CLD | BSY, 2, 3, 1);
    add("bp", I_P, RSP | BSY, 2, 3, 1);
    add("miss_sat", I_V, RDY, 2, 3, 1);
    add("miss_sat", 6'h0, BSY, 2, 3, 1);
    add("miss_sat", 6'h0, MRM | CLV | BSY, 2, 3, 1);
    add("miss_sat", I_R, MRM | MRV | BSY, 2, 3, 1);
    add("miss_sat", I_P, MRM | DFE | BSY, 2, 3, 1);
    add("miss_sat", 6'h0, MRM | LRU | FIN | CLD | BSY, 2, 3, 1);
    add("miss_sat", 6'h0, RSP | BSY, 2, 3, 1);
    add("idle", 6'h0, RDY, 2, 3, 1);
    run_table(0);

    rst_n[0] = 1'b0;
    #1;
    rst_n[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      add("hit_sat", I_V, RDY, sat3(i), 0, 0);
      add("hit_sat", I_M, LRU | BSY, sat3(i), 0, 0);
      add("hit_sat", 6'h0, RSP | BSY, sat3(i + 1), 0, 0);
    end
    add("pre_rst", I_V, RDY, 3, 0, 0);
    add("pre_rst", 6'h0, BSY, 3, 0, 0);
    add("pre_rst", 6'h0, MRM | CLV | BSY, 3, 1, 0);
    add("pre_rst", I_R, MRM | MRV | BSY, 3, 1, 0);
    run_table(0);

    set_inputs(I_V | I_M);
    #1;
    check("fill_wait", actual(0), {MRM | BSY, 2'd3, 2'd1, 2'd0});
    #1;
    rst_n[0] = 1'b0;
    #1;
    check("rst_mid", actual(0), 19'd0);
    @(posedge clk);
    #1;
    check("rst_hold", actual(0), 19'd0);
    rst_n[0] = 1'b1;
    add("post_rst", I_V, RDY, 0, 0, 0);
    add("post_rst", I_M, LRU | BSY, 0, 0, 0);
    add("post_rst", 6'h0, RSP | BSY, 1, 0, 0);
    add("post_rst", 6'h0, RDY, 1, 0, 0);
    run_table(0);

    rst_n = 2'b10;
    add("ro_miss", I_V | I_W, RDY, 0, 0, 0);
    add("ro_miss", I_D, BSY, 0, 0, 0);
    add("ro_miss", I_D, MRM | CLV | BSY, 0, 1, 0);
    add("ro_miss", I_D | I_R, MRM | MRV | BSY, 0, 1, 0);
    add("ro_miss", I_D | I_P, MRM | DFE | BSY, 0, 1, 0);
    add("ro_miss", I_D, MRM | LRU | FIN | BSY, 0, 1, 0);
    add("ro_miss", I_D, RSP | BSY, 0, 1, 0);
    add("ro_hit", I_V | I_W, RDY, 0, 1, 0);
    add("ro_hit", I_M | I_D, LRU | BSY, 0, 1, 0);
    add("ro_hit", 6'h0, RSP | BSY, 1, 1, 0);
    add("ro_hit", 6'h0, RDY, 1, 1, 0);
    run_table(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for one cache level. Accepts one CPU request at a time and drives the metadata (tag/valid/dirty/LRU) control strobes and data-array enables. Runs hit handling, victim writeback, line fill and install against a simple request/response memory port. Also keeps saturating hit/miss/writeback performance counters.

## Interface
- READ_ONLY, 0: 1 disables the write and writeback paths (instruction cache).
- CNT_WIDTH, 16: width of each performance counter.

- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- cpu_req_valid  in  1  request present. Set/tag into metadata held stable by the requester until cpu_resp_valid.
- cpu_req_write  in  1  1 = store, 0 = load. Sampled on acceptance.
- cpu_req_ready  out  1  high only in IDLE; forced 0 while reset_n low.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- valid_block_match  in  1  metadata hit indication.
- valid_dirty_bit  in  1  selected way is valid and dirty.
- miss_recovery_mode  out  1  selects the victim way in metadata.
- process_lru_counters, clear_selected_valid_bit, finish_new_line_install, clear_selected_dirty_bit, set_selected_dirty_bit  out  1 each  metadata strobes, single-cycle.
- mem_req_valid  out  1  memory request.
- mem_req_write  out  1  1 = writeback of selected_tag line, 0 = fill.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  writeback ack / fill data valid.
- data_write_en  out  1  write CPU word into selected way.
- data_fill_en  out  1  capture fill line into selected way.
- busy  out  1  state != IDLE.
- hit_count, miss_count, wb_count  out  CNT_WIDTH each  saturating counters.

## Operation
- States: IDLE, LOOKUP, VICTIM, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, INSTALL, RESPOND. Outputs are Moore decodes of the state plus the latched write flag (wr), except where a condition is stated.
- IDLE: cpu_req_ready=1. On cpu_req_valid, latch wr (forced 0 if READ_ONLY) and go to LOOKUP.
- LOOKUP, with miss_recovery_mode=0:
  - On a hit, assert process_lru_counters. If wr, also assert set_selected_dirty_bit and data_write_en. Increment hit_count, go to RESPOND.
  - On a miss, increment miss_count and go to VICTIM.
- VICTIM: miss_recovery_mode=1, so valid_dirty_bit now refers to the victim way.
  - If valid_dirty_bit and !READ_ONLY, go to WB_REQ.
  - Otherwise assert clear_selected_valid_bit and go to FILL_REQ.
- WB_REQ: mem_req_valid=1, mem_req_write=1. Held until mem_req_ready, then go to WB_WAIT.
- WB_WAIT: on mem_resp_valid, assert clear_selected_valid_bit and clear_selected_dirty_bit, increment wb_count, go to FILL_REQ.
- FILL_REQ: mem_req_valid=1, mem_req_write=0. On mem_req_ready, go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, assert data_fill_en and go to INSTALL.
- INSTALL: assert finish_new_line_install and process_lru_counters.
  - If wr, assert set_selected_dirty_bit and data_write_en.
  - Otherwise assert clear_selected_dirty_bit; stale dirty bits of invalid ways are never trusted.
  - Go to RESPOND.
- RESPOND: cpu_resp_valid=1, go to IDLE.
- miss_recovery_mode=1 in VICTIM, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT and INSTALL; 0 elsewhere.
- READ_ONLY=1: set_selected_dirty_bit, clear_selected_dirty_bit and mem_req_write are tied 0, and WB_* states are unreachable.
- Counters: increment by 1, saturate at all-ones (no wrap).
- The metadata strobes clear_selected_valid_bit and finish_new_line_install are never asserted together.

## Timing
- Reset (async, reset_n=0): state=IDLE, wr=0, counters=0, every output 0 including cpu_req_ready.
- First acceptance is possible on the first clk edge after reset_n deasserts.
- Reset mid-operation: in-flight memory transaction abandoned; the memory side is reset with it.
- Hit latency: accept at edge E0; LOOKUP is the cycle after E0; cpu_resp_valid is high in the second cycle after E0.
- Clean miss, zero memory wait states: LOOKUP, VICTIM, FILL_REQ, FILL_WAIT, INSTALL, RESPOND, giving cpu_resp_valid in the 6th cycle after E0. A dirty miss adds 2 cycles (WB_REQ, WB_WAIT).
- mem_req_valid stays high with stable mem_req_write until mem_req_ready.
- mem_resp_valid is honoured only in WB_WAIT and FILL_WAIT and ignored elsewhere. Memory never responds in the cycle it accepts.
- cpu_req_valid during non-IDLE states is not accepted; no request queueing.

## Test plan
- Read hit (valid_block_match=1 in LOOKUP): cpu_resp_valid 2 cycles after accept; one process_lru_counters pulse; no dirty strobe; hit_count=1.
- Write miss, clean victim (valid_dirty_bit=0), mem_req_ready=1, response 1 cycle later:
  - clear_selected_valid_bit in VICTIM; mem_req_write=0.
  - INSTALL pulses finish_new_line_install, set_selected_dirty_bit and data_write_en.
  - miss_count=1, wb_count=0.
- Read miss, dirty victim: a writeback request (mem_req_write=1) precedes the fill. WB_WAIT clears valid and dirty; INSTALL pulses clear_selected_dirty_bit; wb_count=1.
- Memory backpressure: mem_req_ready low for 5 cycles in FILL_REQ, with a stray mem_resp_valid in FILL_REQ. mem_req_valid stays high for 6 cycles, and the stray response is ignored.
- CNT_WIDTH=2, 5 consecutive read hits: hit_count reads 1,2,3,3,3.
- reset_n low during FILL_WAIT: all outputs 0 immediately. After release, a new read hit completes normally and counters restart from 0.
- READ_ONLY=1, write miss on a valid dirty victim: no WB states entered, no dirty strobes, mem_req_write=0 throughout.
